// File: rtl/hci_core_per_apb_bridge.sv
// HCI core (peripheral branch) to APB3/APB4 bridge.
// Accepts one HCI request at a time, runs a SETUP/ACCESS APB transfer and
// returns the result as a single-cycle r_valid response.
// Optional feature: define HCI_APB_BRIDGE_TIMEOUT_EN to abort ACCESS phases
// that see no pready_i within TIMEOUT_CYCLES cycles.
module hci_core_per_apb_bridge #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  // HCI slave side
  input  logic              slave_req_i,
  output logic              slave_gnt_o,
  input  logic [AW-1:0]     slave_add_i,
  input  logic              slave_wen_i,
  input  logic [DW-1:0]     slave_data_i,
  input  logic [DW/8-1:0]   slave_be_i,
  input  logic [15:0]       slave_boffs_i,
  input  logic              slave_lrdy_i,
  output logic              slave_r_valid_o,
  output logic [DW-1:0]     slave_r_data_o,
  output logic              slave_r_opc_o,
  // APB master side
  output logic [AW-1:0]     paddr_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [DW-1:0]     pwdata_o,
  output logic [DW/8-1:0]   pstrb_o,
  input  logic [DW-1:0]     prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            r_state;
  state_e            w_state_fsm;
  state_e            w_state_nxt;

  logic [AW-1:0]     r_paddr,   w_paddr_nxt;
  logic              r_pwrite,  w_pwrite_nxt;
  logic [DW-1:0]     r_pwdata,  w_pwdata_nxt;
  logic [DW/8-1:0]   r_pstrb,   w_pstrb_nxt;
  logic              r_psel,    w_psel_nxt;
  logic              r_penable, w_penable_nxt;
  logic              r_rvalid,  w_rvalid_nxt;
  logic [DW-1:0]     r_rdata,   w_rdata_nxt;
  logic              r_ropc,    w_ropc_nxt;
  logic              w_gnt_fsm;

`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] ERR_PATTERN = {(DW/32){32'hbadacce5}};
  logic [CW-1:0]     r_cnt, w_cnt_nxt;
`endif

  // Sideband fields the peripheral branch does not use; the TIMEOUT_CYCLES
  // term keeps the parameter referenced when the timeout is compiled out.
  logic w_unused;
  assign w_unused = ^{slave_boffs_i, slave_lrdy_i, (TIMEOUT_CYCLES >= 2)};

  // Next-state, capture and response decode; outputs are registered from these.
  always_comb begin
    w_state_fsm  = r_state;
    w_gnt_fsm    = 1'b0;
    w_paddr_nxt  = r_paddr;
    w_pwrite_nxt = r_pwrite;
    w_pwdata_nxt = r_pwdata;
    w_pstrb_nxt  = r_pstrb;
    w_rdata_nxt  = r_rdata;
    w_ropc_nxt   = r_ropc;
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
    w_cnt_nxt    = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        w_gnt_fsm = slave_req_i;
        // A clear in the same cycle suppresses the capture as well as the grant.
        if (slave_req_i && !clear_i) begin
          w_paddr_nxt  = slave_add_i;
          w_pwrite_nxt = ~slave_wen_i;
          w_pwdata_nxt = slave_data_i;
          w_pstrb_nxt  = slave_be_i;
          w_state_fsm  = S_SETUP;
        end else begin
          w_state_fsm  = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_fsm = S_ACCESS;
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      S_ACCESS: begin
        if (pready_i) begin
          // Writes return zero data; the slave error is the response opcode.
          w_rdata_nxt = r_pwrite ? {DW{1'b0}} : prdata_i;
          w_ropc_nxt  = pslverr_i;
          w_state_fsm = S_RESP;
        end else begin
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
          if (r_cnt == CNT_LAST) begin
            w_rdata_nxt = ERR_PATTERN;
            w_ropc_nxt  = 1'b1;
            w_state_fsm = S_RESP;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
            w_state_fsm = S_ACCESS;
          end
`else
          w_state_fsm = S_ACCESS;
`endif
        end
      end
      S_RESP: begin
        w_state_fsm = S_IDLE;
      end
      default: begin
        w_state_fsm = S_IDLE;
      end
    endcase

    if (clear_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      w_state_nxt = w_state_fsm;
    end

    w_psel_nxt    = (w_state_nxt == S_SETUP) || (w_state_nxt == S_ACCESS);
    w_penable_nxt = (w_state_nxt == S_ACCESS);
    w_rvalid_nxt  = (w_state_nxt == S_RESP);
  end

  // Grant only in IDLE, never during reset or a clear cycle.
  assign slave_gnt_o = w_gnt_fsm & rst_ni & ~clear_i;

  // State and registered output update with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_paddr   <= {AW{1'b0}};
      r_pwrite  <= 1'b0;
      r_pwdata  <= {DW{1'b0}};
      r_pstrb   <= {(DW/8){1'b0}};
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= {DW{1'b0}};
      r_ropc    <= 1'b0;
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_paddr   <= w_paddr_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_pstrb   <= w_pstrb_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_rdata   <= w_rdata_nxt;
      r_ropc    <= w_ropc_nxt;
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
      r_cnt     <= w_cnt_nxt;
`endif
    end
  end

  assign paddr_o         = r_paddr;
  assign pwrite_o        = r_pwrite;
  assign pwdata_o        = r_pwdata;
  assign pstrb_o         = r_pstrb;
  assign psel_o          = r_psel;
  assign penable_o       = r_penable;
  assign slave_r_valid_o = r_rvalid;
  assign slave_r_data_o  = r_rdata;
  assign slave_r_opc_o   = r_ropc;

endmodule

// File: tb/tb_hci_core_per_apb_bridge.sv
// Directed testbench for hci_core_per_apb_bridge (DW=32, TIMEOUT_CYCLES=4).
module tb_hci_core_per_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n, clear;
  logic        req, gnt, wen, lrdy, r_valid, r_opc;
  logic [31:0] add, data, r_data, prdata, paddr, pwdata;
  logic [3:0]  be, pstrb;
  logic [15:0] boffs;
  logic        psel, penable, pwrite, pready, pslverr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_rv    = 0;

  hci_core_per_apb_bridge #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
    .slave_req_i(req), .slave_gnt_o(gnt), .slave_add_i(add), .slave_wen_i(wen),
    .slave_data_i(data), .slave_be_i(be), .slave_boffs_i(boffs), .slave_lrdy_i(lrdy),
    .slave_r_valid_o(r_valid), .slave_r_data_o(r_data), .slave_r_opc_o(r_opc),
    .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
    .pwdata_o(pwdata), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; req = 1'b1; wen = 1'b1; add = 32'h0;
    data = 32'h0; be = 4'h0; boffs = 16'h0; lrdy = 1'b1;
    prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;

    // Reset state
    step(); step();
    chk("rst_gnt", {63'd0, gnt}, 64'd0);
    chk("rst_psel", {63'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_rvalid", {63'd0, r_valid}, 64'd0);
    chk("rst_paddr", {32'd0, paddr}, 64'd0);
    rst_n = 1'b1; req = 1'b0;
    step();

    // Read, zero wait states
    req = 1'b1; wen = 1'b1; add = 32'h1A10_0004; #1;
    chk("rd_gnt_T", {63'd0, gnt}, 64'd1);
    step();                                     // T+1 SETUP
    req = 1'b0; pready = 1'b1; prdata = 32'hCAFE_0001; #1;
    chk("rd_psel_T1", {63'd0, psel}, 64'd1);
    chk("rd_penable_T1", {63'd0, penable}, 64'd0);
    chk("rd_paddr", {32'd0, paddr}, {32'd0, 32'h1A10_0004});
    chk("rd_pwrite", {63'd0, pwrite}, 64'd0);
    step();                                     // T+2 ACCESS
    chk("rd_psel_T2", {63'd0, psel}, 64'd1);
    chk("rd_penable_T2", {63'd0, penable}, 64'd1);
    chk("rd_rvalid_T2", {63'd0, r_valid}, 64'd0);
    step();                                     // T+3 RESP
    chk("rd_rvalid_T3", {63'd0, r_valid}, 64'd1);
    chk("rd_rdata", {32'd0, r_data}, {32'd0, 32'hCAFE_0001});
    chk("rd_ropc", {63'd0, r_opc}, 64'd0);
    chk("rd_psel_T3", {63'd0, psel}, 64'd0);
    pready = 1'b0;
    step();                                     // T+4 IDLE
    chk("rd_rvalid_T4", {63'd0, r_valid}, 64'd0);

    // Write, three wait states
    req = 1'b1; wen = 1'b0; add = 32'h1A10_0008; data = 32'h1234_5678; be = 4'b0011; #1;
    chk("wr_gnt_T", {63'd0, gnt}, 64'd1);
    step();                                     // T+1 SETUP
    req = 1'b0; prdata = 32'hFFFF_FFFF; data = 32'h0; be = 4'h0; #1;
    chk("wr_pwrite", {63'd0, pwrite}, 64'd1);
    chk("wr_pstrb", {60'd0, pstrb}, 64'd3);
    for (int i = 2; i <= 5; i++) begin
      chk("wr_pwdata_stable", {32'd0, pwdata}, {32'd0, 32'h1234_5678});
      chk("wr_psel_held", {63'd0, psel}, 64'd1);
      chk("wr_rvalid_wait", {63'd0, r_valid}, 64'd0);
      step();                                   // T+2 .. T+5 ACCESS
      if (i == 5) pready = 1'b1;
    end
    chk("wr_pwdata_stable_T5", {32'd0, pwdata}, {32'd0, 32'h1234_5678});
    chk("wr_penable_T5", {63'd0, penable}, 64'd1);
    step();                                     // T+6 RESP
    pready = 1'b0;
    chk("wr_rvalid_T6", {63'd0, r_valid}, 64'd1);
    chk("wr_rdata_zero", {32'd0, r_data}, 64'd0);
    chk("wr_ropc", {63'd0, r_opc}, 64'd0);
    step();

    // Slave error on read, then back-to-back request
    req = 1'b1; wen = 1'b1; add = 32'h1A10_000C; #1;
    chk("err_gnt_T", {63'd0, gnt}, 64'd1);
    step();                                     // T+1 SETUP
    req = 1'b0; pslverr = 1'b1; pready = 1'b1; prdata = 32'hDEAD_0003;
    step();                                     // T+2 ACCESS
    step();                                     // T+3 RESP
    pslverr = 1'b0; pready = 1'b0;
    req = 1'b1; add = 32'h1A10_0010; #1;
    chk("err_rvalid", {63'd0, r_valid}, 64'd1);
    chk("err_ropc", {63'd0, r_opc}, 64'd1);
    chk("err_rdata", {32'd0, r_data}, {32'd0, 32'hDEAD_0003});
    chk("err_no_gnt_in_resp", {63'd0, gnt}, 64'd0);
    step();                                     // T+4 IDLE
    chk("b2b_gnt_T4", {63'd0, gnt}, 64'd1);

    // Clear during ACCESS wait
    step();                                     // SETUP
    req = 1'b0;
    step();                                     // ACCESS, pready=0
    step();                                     // ACCESS wait
    clear = 1'b1; req = 1'b1; #1;
    chk("clr_gnt_forced0", {63'd0, gnt}, 64'd0);
    step();
    clear = 1'b0; #1;
    chk("clr_psel", {63'd0, psel}, 64'd0);
    chk("clr_penable", {63'd0, penable}, 64'd0);
    chk("clr_rvalid", {63'd0, r_valid}, 64'd0);
    chk("clr_next_gnt", {63'd0, gnt}, 64'd1);

    // Reset while psel is high
    step();                                     // SETUP
    chk("rstm_psel_before", {63'd0, psel}, 64'd1);
    rst_n = 1'b0; #1;
    chk("rstm_gnt", {63'd0, gnt}, 64'd0);
    step();
    rst_n = 1'b1; req = 1'b0; #1;
    chk("rstm_psel", {63'd0, psel}, 64'd0);
    chk("rstm_penable", {63'd0, penable}, 64'd0);
    chk("rstm_paddr", {32'd0, paddr}, 64'd0);
    chk("rstm_pwrite", {63'd0, pwrite}, 64'd0);
    chk("rstm_pwdata", {32'd0, pwdata}, 64'd0);
    chk("rstm_pstrb", {60'd0, pstrb}, 64'd0);
    chk("rstm_rvalid", {63'd0, r_valid}, 64'd0);
    chk("rstm_rdata", {32'd0, r_data}, 64'd0);
    chk("rstm_ropc", {63'd0, r_opc}, 64'd0);

    // Clear with a request in IDLE: no grant, no transfer
    req = 1'b1; clear = 1'b1; #1;
    chk("clr_idle_gnt", {63'd0, gnt}, 64'd0);
    step();
    req = 1'b0; clear = 1'b0; #1;
    chk("clr_idle_psel", {63'd0, psel}, 64'd0);

    // Stalled ACCESS: timeout or indefinite wait
    req = 1'b1; wen = 1'b1; add = 32'h1A10_0020; #1;
    chk("to_gnt", {63'd0, gnt}, 64'd1);
    step();                                     // SETUP
    req = 1'b0; pready = 1'b0;
    step();                                     // ACCESS entry (A)
`ifdef HCI_APB_BRIDGE_TIMEOUT_EN
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("to_rvalid_wait", {63'd0, r_valid}, 64'd0);
    end
    step();                                     // A+4
    chk("to_rvalid", {63'd0, r_valid}, 64'd1);
    chk("to_rdata", {32'd0, r_data}, {32'd0, 32'hBADA_CCE5});
    chk("to_ropc", {63'd0, r_opc}, 64'd1);
    chk("to_psel", {63'd0, psel}, 64'd0);
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (r_valid) n_rv++;
    end
    chk("nto_rvalid_count", 64'(n_rv), 64'd0);
    chk("nto_psel_held", {63'd0, psel}, 64'd1);
    chk("nto_penable_held", {63'd0, penable}, 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
